// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - condition-code encodings and ALU flag bit positions for branch_unit
package branch_pkg;

    typedef enum logic [2:0] {
        CC_ALWAYS = 3'b000,
        CC_Z      = 3'b001,
        CC_P      = 3'b010,
        CC_N      = 3'b011,
        CC_C      = 3'b100,
        CC_V      = 3'b101,
        CC_NEVER6 = 3'b110,
        CC_NEVER7 = 3'b111
    } cc_e;

    localparam int FLAG_Z = 5;
    localparam int FLAG_P = 4;
    localparam int FLAG_N = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 1;

endpackage

// File: rtl/branch_cond.sv
// rtl/branch_cond.sv - combinational branch condition evaluation from cc selector and ALU flags
module branch_cond
    import branch_pkg::*;
(
    input  logic [2:0] cc_i,
    input  logic [5:0] flags_i,
    output logic       taken
);

    cc_e cc;
    assign cc = cc_e'(cc_i);

    // Bit 0 of the flag bus is reserved and deliberately ignored.
    logic unused_flag_rsvd;
    assign unused_flag_rsvd = flags_i[0];

    always_comb begin
        taken = 1'b0;
        case (cc)
            CC_ALWAYS: taken = 1'b1;
            CC_Z:      taken = flags_i[FLAG_Z];
            CC_P:      taken = flags_i[FLAG_P];
            CC_N:      taken = flags_i[FLAG_N];
            CC_C:      taken = flags_i[FLAG_C];
            CC_V:      taken = flags_i[FLAG_V];
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - branch target/condition unit with registered stage; BRANCH_PERF_CNT_EN adds branch counters
module branch_unit
    import branch_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_i,
    input  logic [2:0]  cc_i,
    input  logic [5:0]  flags_i,
    input  logic [31:0] src_i,
    input  logic        abs_i,
    input  logic        valid_i,
    output logic [31:0] dest_addr_o,
    output logic        branch_en_o,
    output logic [31:0] dest_addr_q_o,
    output logic        branch_en_q_o
`ifdef BRANCH_PERF_CNT_EN
    ,
    output logic [31:0] branch_cnt_o,
    output logic [31:0] taken_cnt_o
`endif
);

    logic cond_taken;

    branch_cond u_cond (
        .cc_i    (cc_i),
        .flags_i (flags_i),
        .taken   (cond_taken)
    );

    // Combinational paths are independent of valid_i and rst_i.
    assign branch_en_o = cond_taken;
    assign dest_addr_o = abs_i ? src_i : (pc_i + src_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dest_addr_q_o <= 32'h0000_0000;
            branch_en_q_o <= 1'b0;
        end else if (valid_i) begin
            dest_addr_q_o <= dest_addr_o;
            branch_en_q_o <= branch_en_o;
        end else begin
            branch_en_q_o <= 1'b0;
        end
    end

`ifdef BRANCH_PERF_CNT_EN
    // Both counters wrap naturally at 2^32.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            branch_cnt_o <= 32'h0000_0000;
            taken_cnt_o  <= 32'h0000_0000;
        end else if (valid_i) begin
            branch_cnt_o <= branch_cnt_o + 32'd1;
            if (branch_en_o) begin
                taken_cnt_o <= taken_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_unit.sv
// tb/tb_branch_unit.sv - directed self-checking bench for branch_unit (optionally with BRANCH_PERF_CNT_EN)
module tb_branch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic [2:0]  cc;
    logic [5:0]  flags;
    logic [31:0] src;
    logic        abs_sel;
    logic        valid;
    logic [31:0] dest_addr;
    logic        branch_en;
    logic [31:0] dest_addr_q;
    logic        branch_en_q;
`ifdef BRANCH_PERF_CNT_EN
    logic [31:0] branch_cnt;
    logic [31:0] taken_cnt;
`endif

    int checks;
    int failures;

    branch_unit dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .pc_i          (pc),
        .cc_i          (cc),
        .flags_i       (flags),
        .src_i         (src),
        .abs_i         (abs_sel),
        .valid_i       (valid),
        .dest_addr_o   (dest_addr),
        .branch_en_o   (branch_en),
        .dest_addr_q_o (dest_addr_q),
        .branch_en_q_o (branch_en_q)
`ifdef BRANCH_PERF_CNT_EN
        ,
        .branch_cnt_o  (branch_cnt),
        .taken_cnt_o   (taken_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; valid = 1'b0; cc = 3'd0; flags = 6'd0;
        pc = 32'h1; src = 32'h2; abs_sel = 1'b0;
        #12;
        checks++;
        if (dest_addr_q !== 32'h0) begin
            failures++; $display("FAIL reset_dest_q got=%h exp=%h", dest_addr_q, 32'h0);
        end
        checks++;
        if (branch_en_q !== 1'b0) begin
            failures++; $display("FAIL reset_en_q got=%b exp=0", branch_en_q);
        end
        checks++;
        if (dest_addr !== 32'h3) begin
            failures++; $display("FAIL comb_during_reset got=%h exp=%h", dest_addr, 32'h3);
        end
        checks++;
        if (branch_en !== 1'b1) begin
            failures++; $display("FAIL en_during_reset got=%b exp=1", branch_en);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_dest_addr();
        logic [31:0] exp;
        pc = 32'h1; src = 32'h2; abs_sel = 1'b0; #1;
        checks++;
        if (dest_addr !== 32'h3) begin
            failures++; $display("FAIL rel_basic got=%h exp=%h", dest_addr, 32'h3);
        end
        abs_sel = 1'b1; #1;
        checks++;
        if (dest_addr !== 32'h2) begin
            failures++; $display("FAIL abs_basic got=%h exp=%h", dest_addr, 32'h2);
        end
        pc = 32'hFFFF_FFFF; src = 32'h2; abs_sel = 1'b0; #1;
        checks++;
        if (dest_addr !== 32'h1) begin
            failures++; $display("FAIL rel_wrap got=%h exp=%h", dest_addr, 32'h1);
        end
        for (int i = 0; i < 40; i++) begin
            pc = $urandom; src = $urandom; abs_sel = (i >= 20);
            exp = abs_sel ? src : pc + src;
            #1;
            checks++;
            if (dest_addr !== exp) begin
                failures++;
                $display("FAIL rand_dest abs=%b pc=%h src=%h got=%h exp=%h", abs_sel, pc, src, dest_addr, exp);
            end
        end
    endtask

    task automatic test_cond();
        logic [5:0] one_hot;
        for (int c = 1; c <= 5; c++) begin
            cc = 3'(c);
            flags = 6'b000000; #1;
            checks++;
            if (branch_en !== 1'b0) begin
                failures++; $display("FAIL cond_clear cc=%0d got=%b exp=0", c, branch_en);
            end
            one_hot = 6'b100000 >> (c - 1);
            flags = one_hot; #1;
            checks++;
            if (branch_en !== 1'b1) begin
                failures++; $display("FAIL cond_set cc=%0d flags=%b got=%b exp=1", c, flags, branch_en);
            end
            flags = ~one_hot; #1;
            checks++;
            if (branch_en !== 1'b0) begin
                failures++; $display("FAIL cond_others cc=%0d flags=%b got=%b exp=0", c, flags, branch_en);
            end
        end
        cc = 3'd0; flags = 6'b000000; #1;
        checks++;
        if (branch_en !== 1'b1) begin
            failures++; $display("FAIL cond_always got=%b exp=1", branch_en);
        end
        for (int c = 6; c <= 7; c++) begin
            cc = 3'(c); flags = 6'b111111; #1;
            checks++;
            if (branch_en !== 1'b0) begin
                failures++; $display("FAIL cond_never cc=%0d got=%b exp=0", c, branch_en);
            end
        end
        for (int c = 0; c <= 7; c++) begin
            cc = 3'(c); flags = 6'b000001; #1;
            checks++;
            if (branch_en !== (c == 0)) begin
                failures++; $display("FAIL flag0_ignored cc=%0d got=%b exp=%b", c, branch_en, (c == 0));
            end
        end
    endtask

    task automatic test_registered();
        @(negedge clk);
        valid = 1'b1; cc = 3'b001; flags = 6'b100000; pc = 32'h100; src = 32'h10; abs_sel = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (branch_en_q !== 1'b1) begin
            failures++; $display("FAIL reg_taken_en got=%b exp=1", branch_en_q);
        end
        checks++;
        if (dest_addr_q !== 32'h110) begin
            failures++; $display("FAIL reg_taken_dest got=%h exp=%h", dest_addr_q, 32'h110);
        end
        @(negedge clk);
        valid = 1'b0; pc = 32'h500;
        @(posedge clk); #1;
        checks++;
        if (branch_en_q !== 1'b0) begin
            failures++; $display("FAIL reg_idle_en got=%b exp=0", branch_en_q);
        end
        checks++;
        if (dest_addr_q !== 32'h110) begin
            failures++; $display("FAIL reg_idle_hold got=%h exp=%h", dest_addr_q, 32'h110);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_addr;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            valid = 1'b1; cc = 3'b000; flags = 6'd0; abs_sel = 1'b0;
            pc = 32'h1000 * (i + 1); src = 32'h8;
            exp_addr = 32'h1000 * (i + 1) + 32'h8;
            @(posedge clk); #1;
            checks++;
            if (branch_en_q !== 1'b1 || dest_addr_q !== exp_addr) begin
                failures++;
                $display("FAIL b2b_taken i=%0d en=%b dest=%h exp_en=1 exp_dest=%h", i, branch_en_q, dest_addr_q, exp_addr);
            end
        end
        @(negedge clk);
        valid = 1'b1; cc = 3'b110; flags = 6'b111111; abs_sel = 1'b1; src = 32'hABCD_0000;
        @(posedge clk); #1;
        checks++;
        if (branch_en_q !== 1'b0 || dest_addr_q !== 32'hABCD_0000) begin
            failures++;
            $display("FAIL b2b_not_taken en=%b dest=%h exp_en=0 exp_dest=%h", branch_en_q, dest_addr_q, 32'hABCD_0000);
        end
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        valid = 1'b1; cc = 3'b000; pc = 32'h40; src = 32'h4; abs_sel = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (branch_en_q !== 1'b1 || dest_addr_q !== 32'h44) begin
            failures++; $display("FAIL pre_reset en=%b dest=%h exp_en=1 exp_dest=%h", branch_en_q, dest_addr_q, 32'h44);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (branch_en_q !== 1'b0 || dest_addr_q !== 32'h0) begin
            failures++; $display("FAIL async_reset en=%b dest=%h exp_en=0 exp_dest=0", branch_en_q, dest_addr_q);
        end
        @(negedge clk);
        valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (branch_en_q !== 1'b0 || dest_addr_q !== 32'h0) begin
            failures++; $display("FAIL post_reset_idle en=%b dest=%h exp_en=0 exp_dest=0", branch_en_q, dest_addr_q);
        end
        @(negedge clk);
        valid = 1'b1; pc = 32'h200; src = 32'h4;
        @(posedge clk); #1;
        checks++;
        if (branch_en_q !== 1'b1 || dest_addr_q !== 32'h204) begin
            failures++; $display("FAIL post_reset_first en=%b dest=%h exp_en=1 exp_dest=%h", branch_en_q, dest_addr_q, 32'h204);
        end
        @(negedge clk);
        valid = 1'b0;
    endtask

`ifdef BRANCH_PERF_CNT_EN
    task automatic test_counters();
        @(negedge clk);
        rst = 1'b1; valid = 1'b0;
        #1;
        checks++;
        if (branch_cnt !== 32'd0 || taken_cnt !== 32'd0) begin
            failures++; $display("FAIL cnt_reset branch=%0d taken=%0d exp=0/0", branch_cnt, taken_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        valid = 1'b1; cc = 3'b000; flags = 6'd0;
        @(negedge clk);
        valid = 1'b1; cc = 3'b111; flags = 6'b111111;
        @(negedge clk);
        valid = 1'b0; cc = 3'b000;
        @(negedge clk);
        valid = 1'b1; cc = 3'b001; flags = 6'b100000;
        @(negedge clk);
        valid = 1'b0;
        checks++;
        if (branch_cnt !== 32'd3) begin
            failures++; $display("FAIL branch_cnt got=%0d exp=3", branch_cnt);
        end
        checks++;
        if (taken_cnt !== 32'd2) begin
            failures++; $display("FAIL taken_cnt got=%0d exp=2", taken_cnt);
        end
    endtask
`endif

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_dest_addr();
        test_cond();
        test_registered();
        test_back_to_back();
        test_async_reset();
`ifdef BRANCH_PERF_CNT_EN
        test_counters();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_unit.md
BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 SHALL have ports: clk_i  input  1  sole clock, all state on rising edge.
REQ-002 SHALL have: rst_i  input  1  asynchronous, active-high reset.
REQ-003 SHALL have: pc_i  input  32  address of the branch instruction.
REQ-004 SHALL have: cc_i  input  3  condition code selector.
REQ-005 SHALL have: flags_i  input  6  ALU flags; [5]=Z, [4]=P, [3]=N, [2]=C, [1]=V, [0] reserved.
REQ-006 SHALL have: src_i  input  32  branch offset (relative) or target (absolute).
REQ-007 SHALL have: abs_i  input  1  1 = absolute target, 0 = pc-relative.
REQ-008 SHALL have: valid_i  input  1  qualifies a branch instruction for the registered stage.
REQ-009 SHALL have: dest_addr_o  output  32  combinational branch target.
REQ-010 SHALL have: branch_en_o  output  1  combinational condition-met flag.
REQ-011 SHALL have: dest_addr_q_o  output  32  registered target of last valid branch.
REQ-012 SHALL have: branch_en_q_o  output  1  registered taken pulse, 1 cycle after a valid taken branch.

Function
REQ-013 dest_addr_o SHALL equal src_i when abs_i=1, else (pc_i + src_i) mod 2^32, carry discarded, zero latency.
REQ-014 branch_en_o SHALL be combinational: cc 000 -> 1; 001 -> Z; 010 -> P; 011 -> N; 100 -> C; 101 -> V; 110/111 -> 0.
REQ-015 flags_i[0] SHALL never influence any output.
REQ-016 Combinational outputs SHALL be valid regardless of valid_i and of reset state.
REQ-017 On each rising clk_i with valid_i=1: branch_en_q_o <= branch_en_o; dest_addr_q_o <= dest_addr_o.
REQ-018 On rising clk_i with valid_i=0: branch_en_q_o <= 0; dest_addr_q_o holds.
REQ-019 branch_en_q_o SHALL never be 1 for more cycles than consecutive valid taken branches.

Reset
REQ-020 While rst_i=1, dest_addr_q_o = 0x00000000 and branch_en_q_o = 0, immediately (asynchronous).
REQ-021 Reset asserted mid-operation SHALL discard pending state; first update after release on next rising edge with valid_i=1.
REQ-022 Combinational outputs SHALL be unaffected by rst_i.

Configuration
REQ-023 Macro BRANCH_PERF_CNT_EN, when defined, SHALL add outputs branch_cnt_o[31:0] (valid branches) and taken_cnt_o[31:0] (valid taken branches).
REQ-024 Counters SHALL increment on rising clk_i, reset to 0 asynchronously, and wrap from 0xFFFFFFFF to 0.
REQ-025 Without the macro, the counter ports and logic SHALL be absent; all other behaviour identical.

Structure
REQ-026 Package branch_pkg SHALL hold cc encodings (CC_ALWAYS..CC_V) and flag bit indices (FLAG_Z..FLAG_V).
REQ-027 Condition evaluation SHALL be a sub-module branch_cond (cc_i, flags_i -> taken), instantiated once.

Verification
REQ-028 pc=0x00000001, src=0x00000002, abs=0 -> dest_addr_o=0x00000003; abs=1 -> 0x00000002.
REQ-029 pc=0xFFFFFFFF, src=0x00000002, abs=0 -> dest_addr_o=0x00000001 (wrap).
REQ-030 For each cc 001..101: flags=000000 -> branch_en_o=0; only the matching flag bit set (100000, 010000, 001000, 000100, 000010) -> 1; cc=000 with flags=0 -> 1; cc=110/111 with flags=111111 -> 0.
REQ-031 20 random pc/src pairs per mode: relative -> pc+src, absolute -> src.
REQ-032 valid_i=1, cc=001, flags=100000, pc=0x100, src=0x10 -> next cycle branch_en_q_o=1, dest_addr_q_o=0x110; valid_i=0 next -> branch_en_q_o=0, dest_addr_q_o holds 0x110.
REQ-033 Assert rst_i between clock edges -> registered outputs 0 immediately; with BRANCH_PERF_CNT_EN, 3 valid branches (2 taken) -> branch_cnt_o=3, taken_cnt_o=2.
